// File: rtl/jpeg_quant_pkg.sv
// ---------------------------------------------------------------------------
// jpeg_quant_pkg
// Constants, the standard JPEG luma/chroma quantization tables and the
// dequantizer FSM state type. Shared by quantize_array and dequantize_array.
// ---------------------------------------------------------------------------
package jpeg_quant_pkg;

    localparam int PIXEL_COUNT = 64;   // coefficients per 8x8 block
    localparam int COEF_W      = 16;   // quantized coefficient width
    localparam int Q16_W       = 32;   // Q16.16 output width
    localparam int TAB_W       = 8;    // quantization table entry width

    typedef enum logic [1:0] {
        DQ_IDLE = 2'd0,
        DQ_RUN  = 2'd1,
        DQ_DONE = 2'd2
    } dq_state_t;

    // Standard luminance table, raster order.
    localparam logic [TAB_W-1:0] LUMA_TBL [0:PIXEL_COUNT-1] = '{
        8'd16,  8'd11,  8'd10,  8'd16,  8'd24,  8'd40,  8'd51,  8'd61,
        8'd12,  8'd12,  8'd14,  8'd19,  8'd26,  8'd58,  8'd60,  8'd55,
        8'd14,  8'd13,  8'd16,  8'd24,  8'd40,  8'd57,  8'd69,  8'd56,
        8'd14,  8'd17,  8'd22,  8'd29,  8'd51,  8'd87,  8'd80,  8'd62,
        8'd18,  8'd22,  8'd37,  8'd56,  8'd68,  8'd109, 8'd103, 8'd77,
        8'd24,  8'd35,  8'd55,  8'd64,  8'd81,  8'd104, 8'd113, 8'd92,
        8'd49,  8'd64,  8'd78,  8'd87,  8'd103, 8'd121, 8'd120, 8'd101,
        8'd72,  8'd92,  8'd95,  8'd98,  8'd112, 8'd100, 8'd103, 8'd99
    };

    // Standard chrominance table, raster order.
    localparam logic [TAB_W-1:0] CHROMA_TBL [0:PIXEL_COUNT-1] = '{
        8'd17,  8'd18,  8'd24,  8'd47,  8'd99,  8'd99,  8'd99,  8'd99,
        8'd18,  8'd21,  8'd26,  8'd66,  8'd99,  8'd99,  8'd99,  8'd99,
        8'd24,  8'd26,  8'd56,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,
        8'd47,  8'd66,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,
        8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,
        8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,
        8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,
        8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99
    };

    function automatic logic [TAB_W-1:0] qtable(input logic luma, input logic [5:0] idx);
        return luma ? LUMA_TBL[idx] : CHROMA_TBL[idx];
    endfunction

endpackage

// File: rtl/dequant_lane.sv
// ---------------------------------------------------------------------------
// dequant_lane
// One dequantization multiplier: q (signed 16) x T (unsigned 8), formatted as
// Q16.16 with a zero fraction. Purely combinational.
// Build option: DEQUANT_SATURATE_EN defined -> products outside the 16-bit
// signed range clamp; undefined -> the integer part wraps.
// Ports:
//   i_q    signed quantized coefficient
//   i_t    quantization table entry
//   o_res  Q16.16 result
// ---------------------------------------------------------------------------
module dequant_lane
    import jpeg_quant_pkg::*;
(
    input  logic signed [COEF_W-1:0] i_q,
    input  logic        [TAB_W-1:0]  i_t,
    output logic        [Q16_W-1:0]  o_res
);

`ifdef DEQUANT_SATURATE_EN
    logic signed [23:0] w_qx;
    logic signed [23:0] w_tx;
    logic signed [23:0] w_prod;

    // Both operands widened to 24 bits; the table entry is zero-extended so
    // the multiply is signed x unsigned. |q*T| < 2^23, so 24 bits is exact.
    assign w_qx   = {{(24-COEF_W){i_q[COEF_W-1]}}, i_q};
    assign w_tx   = {{(24-TAB_W){1'b0}}, i_t};
    assign w_prod = w_qx * w_tx;

    function automatic logic [Q16_W-1:0] sat_q16(input logic signed [23:0] p);
        if (p > 24'sd32767)
            return 32'h7FFF_0000;
        else if (p < -24'sd32768)
            return 32'h8000_0000;
        else
            return {p[15:0], 16'h0000};
    endfunction

    assign o_res = sat_q16(w_prod);
`else
    logic [15:0] w_lo;

    // The low 16 bits of a product depend only on the low 16 bits of the
    // operands, so the wrapped result needs just a 16x16 truncated multiply.
    assign w_lo = $unsigned(i_q) * {8'h00, i_t};

    function automatic logic [Q16_W-1:0] wrap_q16(input logic [15:0] lo);
        return {lo, 16'h0000};
    endfunction

    assign o_res = wrap_q16(w_lo);
`endif

endmodule

// File: rtl/dequantize_array.sv
// ---------------------------------------------------------------------------
// dequantize_array
// Multiplies an 8x8 block of quantized coefficients by the JPEG luma or
// chroma quantization table, LANES coefficients per cycle, producing 64
// Q16.16 values for the IDCT. Start/done handshake: start sampled in IDLE or
// DONE captures the block; done is high while pixels holds a full result.
// Build option: DEQUANT_SATURATE_EN (see dequant_lane) selects saturation
// instead of wrap on overflow.
// Parameters:
//   USE_LUMA  1 = luma table, 0 = chroma table
//   LANES     coefficients per cycle (1,2,4,8,16,32,64)
// Ports:
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   start     block request
//   q_coeffs  64 x 16-bit signed, element i at [i*16 +: 16]
//   pixels    64 x 32-bit Q16.16, element i at [i*32 +: 32]
//   done      result valid level
// ---------------------------------------------------------------------------
module dequantize_array
    import jpeg_quant_pkg::*;
#(
    parameter bit USE_LUMA = 1'b1,
    parameter int LANES    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [PIXEL_COUNT*COEF_W-1:0] q_coeffs,
    output logic [PIXEL_COUNT*Q16_W-1:0]  pixels,
    output logic                          done
);

    localparam int GROUPS = PIXEL_COUNT / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    dq_state_t r_state;
    dq_state_t w_state_nxt;
    logic      w_capture;
    logic      w_last;

    logic        [GW-1:0]     r_grp;
    logic signed [COEF_W-1:0] r_q   [PIXEL_COUNT];
    logic        [Q16_W-1:0]  r_pix [PIXEL_COUNT];

    logic        [5:0]        w_idx [LANES];
    logic signed [COEF_W-1:0] w_q   [LANES];
    logic        [TAB_W-1:0]  w_t   [LANES];
    logic        [Q16_W-1:0]  w_res [LANES];

    assign w_last = (r_grp == GW'(GROUPS - 1));

    // Next-state and capture decode
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            DQ_IDLE: begin
                if (start) begin
                    w_state_nxt = DQ_RUN;
                    w_capture   = 1'b1;
                end
            end
            DQ_RUN: begin
                // start is deliberately not looked at here: no queueing.
                if (w_last)
                    w_state_nxt = DQ_DONE;
            end
            DQ_DONE: begin
                if (start) begin
                    w_state_nxt = DQ_RUN;
                    w_capture   = 1'b1;
                end
            end
            default: w_state_nxt = DQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= DQ_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Lane datapath: each lane handles element grp*LANES+k of the block
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_idx[k] = 6'(int'(r_grp) * LANES + k);
        assign w_q[k]   = r_q[w_idx[k]];
        assign w_t[k]   = qtable(USE_LUMA, w_idx[k]);

        dequant_lane u_lane (
            .i_q   (w_q[k]),
            .i_t   (w_t[k]),
            .o_res (w_res[k])
        );
    end

    // Capture / result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grp <= '0;
            for (int i = 0; i < PIXEL_COUNT; i++) begin
                r_q[i]   <= '0;
                r_pix[i] <= '0;
            end
        end else if (w_capture) begin
            // pixels is left alone here; old values persist until overwritten.
            r_grp <= '0;
            for (int i = 0; i < PIXEL_COUNT; i++)
                r_q[i] <= q_coeffs[i*COEF_W +: COEF_W];
        end else if (r_state == DQ_RUN) begin
            for (int k = 0; k < LANES; k++)
                r_pix[w_idx[k]] <= w_res[k];
            r_grp <= w_last ? '0 : r_grp + 1'b1;
        end
    end

    for (genvar i = 0; i < PIXEL_COUNT; i++) begin : g_out
        assign pixels[i*Q16_W +: Q16_W] = r_pix[i];
    end

    assign done = (r_state == DQ_DONE);

endmodule

// File: tb/tb_dequantize_array.sv
module tb_dequantize_array;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1023:0] q_coeffs;
    logic [2047:0] pixels;
    logic          done;
    logic [2047:0] pixels_l;
    logic          done_l;

    int n_checks = 0;
    int n_fail   = 0;

    dequantize_array #(.USE_LUMA(1'b0), .LANES(8)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .q_coeffs (q_coeffs),
        .pixels   (pixels),
        .done     (done)
    );

    dequantize_array #(.USE_LUMA(1'b1), .LANES(8)) u_dut_luma (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .q_coeffs (q_coeffs),
        .pixels   (pixels_l),
        .done     (done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] px(input logic [2047:0] v, input int i);
        return v[i*32 +: 32];
    endfunction

    task automatic set_all(input logic [15:0] v);
        for (int i = 0; i < 64; i++)
            q_coeffs[i*16 +: 16] = v;
    endtask

    task automatic set_one(input int idx, input logic [15:0] v);
        q_coeffs = '0;
        q_coeffs[idx*16 +: 16] = v;
    endtask

    // Waits for done, returning the number of edges waited (-1 on timeout).
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(posedge clk);
            #1;
            if (done) lat = n;
        end
    endtask

    task automatic pulse_run(output int lat);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
    endtask

    initial begin
        int lat;
        logic [31:0] exp_sat;

        rst_n    = 1'b0;
        start    = 1'b0;
        q_coeffs = '0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_pix", {31'b0, |pixels}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_done", {31'b0, done}, 32'd0);
        check("idle_pix", {31'b0, |pixels}, 32'd0);

        // Chroma, all ones
        set_all(16'h0001);
        pulse_run(lat);
        check("ones_lat", 32'(lat), 32'd8);
        check("ones_p0", px(pixels, 0), 32'h0011_0000);
        check("ones_p1", px(pixels, 1), 32'h0012_0000);
        check("ones_p9", px(pixels, 9), 32'h0015_0000);
        check("ones_p63", px(pixels, 63), 32'h0063_0000);
        check("ones_luma_p0", px(pixels_l, 0), 32'h0010_0000);
        check("ones_luma_p5", px(pixels_l, 5), 32'h0028_0000);

        // Negative coefficient, all others zero
        set_one(0, 16'hFFFD);
        pulse_run(lat);
        check("neg_lat", 32'(lat), 32'd8);
        check("neg_p0", px(pixels, 0), 32'hFFCD_0000);
        check("neg_rest", {31'b0, |pixels[2047:32]}, 32'd0);
        check("neg_luma_p0", px(pixels_l, 0), 32'hFFD0_0000);
        check("neg_luma_done", {31'b0, done_l}, 32'd1);

        // Overflow behaviour at element 63
`ifdef DEQUANT_SATURATE_EN
        exp_sat = 32'h7FFF_0000;
`else
        exp_sat = 32'h7F9D_0000;
`endif
        set_one(63, 16'h7FFF);
        pulse_run(lat);
        check("ovf_pos_p63", px(pixels, 63), exp_sat);
        check("ovf_pos_p0", px(pixels, 0), 32'd0);
        set_one(63, 16'h8000);
        pulse_run(lat);
        check("ovf_neg_p63", px(pixels, 63), 32'h8000_0000);

        // start during RUN is ignored; q changes after capture do not matter
        set_all(16'h0001);
        start = 1'b1;
        @(posedge clk);             // E0
        #1 start = 1'b0;
        set_all(16'h0002);
        @(posedge clk);             // E1
        #1;
        @(posedge clk);             // E2
        #1 start = 1'b1;
        @(posedge clk);             // E3
        #1 start = 1'b0;
        repeat (4) @(posedge clk);  // E7
        #1;
        check("ign_e7_done", {31'b0, done}, 32'd0);
        @(posedge clk);             // E8
        #1;
        check("ign_e8_done", {31'b0, done}, 32'd1);
        check("ign_p0", px(pixels, 0), 32'h0011_0000);
        check("ign_p63", px(pixels, 63), 32'h0063_0000);
        repeat (3) @(posedge clk);
        #1;
        check("ign_hold", {31'b0, done}, 32'd1);

        // start held high: back-to-back blocks
        set_all(16'h0003);
        start = 1'b1;
        @(posedge clk);             // restart edge
        #1;
        check("b2b_fall", {31'b0, done}, 32'd0);
        wait_done(lat);
        check("b2b_lat", 32'(lat), 32'd8);
        check("b2b_p0", px(pixels, 0), 32'h0033_0000);
        check("b2b_p63", px(pixels, 63), 32'h0129_0000);
        set_all(16'h0004);
        @(posedge clk);             // second restart edge
        #1;
        check("b2b_fall2", {31'b0, done}, 32'd0);
        check("b2b_keep_p0", px(pixels, 0), 32'h0033_0000);
        @(posedge clk);             // group 0 of new block
        #1 start = 1'b0;
        check("b2b_new_p0", px(pixels, 0), 32'h0044_0000);
        check("b2b_old_p63", px(pixels, 63), 32'h0129_0000);
        wait_done(lat);
        check("b2b_done2", {31'b0, done}, 32'd1);
        check("b2b_p63_2", px(pixels, 63), 32'h018C_0000);

        // Reset in the middle of RUN
        set_all(16'h0005);
        start = 1'b1;
        @(posedge clk);             // E0
        #1 start = 1'b0;
        repeat (3) @(posedge clk);  // E3
        #1 rst_n = 1'b0;
        @(posedge clk);             // E4
        #1;
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_pix", {31'b0, |pixels}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_idle", {31'b0, done}, 32'd0);
        set_all(16'h0001);
        pulse_run(lat);
        check("post_rst_lat", 32'(lat), 32'd8);
        check("post_rst_p0", px(pixels, 0), 32'h0011_0000);
        check("post_rst_p8", px(pixels, 8), 32'h0012_0000);
        check("post_rst_p63", px(pixels, 63), 32'h0063_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dequantize_array.md
# dequantize_array

Inverse of `quantize_array` on the decoder side of the JPEG pipeline. The block takes one 8×8 block of 16-bit signed quantized coefficients and multiplies each by its luma or chroma quantization-table entry. It produces 64 Q16.16 DCT coefficients for the IDCT stage. Processing is time-multiplexed over `LANES` multipliers and uses a start/done handshake identical in shape to `quantize_array`.

## Interface
- `USE_LUMA`, 1: 1 selects the JPEG luma table, 0 selects the chroma table.
- `LANES`, 8: coefficients processed per cycle. Legal values are 1, 2, 4, 8, 16, 32 and 64.
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  reset; synchronous, active-low.
- `start`  input  1  request to dequantize the block on `q_coeffs`. Sampled only in IDLE or DONE.
- `q_coeffs`  input  1024  64 × 16-bit signed, element i at `[i*16 +: 16]`, zig-zag-free raster order.
- `pixels`  output  2048  64 × 32-bit signed Q16.16, element i at `[i*32 +: 32]`.
- `done`  output  1  level; high while `pixels` holds a complete result.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE to RUN on `start`:
  - `q_coeffs` is captured into an internal 1024-bit register.
  - group counter `grp` is cleared to 0.
- RUN, each cycle:
  - for k in 0..LANES-1, with i = grp*LANES+k: `pixels[i] = result(q[i], T[i])`.
  - `grp` increments.
- RUN to DONE on the cycle that writes the last group, when `grp` = 64/LANES−1. `done` is set.
- DONE to RUN on `start`:
  - new capture, `grp` cleared, `done` cleared.
  - `pixels` keeps its old contents until each group is overwritten.
- DONE with no `start`: the block holds. `pixels` and `done` are stable.
- `start` during RUN is ignored. There is no queueing.
- Arithmetic:
  - the product p = q × T is a 16-bit signed × 8-bit unsigned multiply, giving a 24-bit signed result.
  - result = {p[15:0], 16'h0000}: integer part in bits [31:16], fraction zero.
- Overflow, when p falls outside −32768..32767, is handled according to Configuration.
- `q_coeffs` may change freely after the capture edge.

## Timing
- Reset applies on any edge where `rst_n`=0, including mid-RUN. Reset values:
  - state = IDLE
  - `grp` = 0
  - `done` = 0
  - `pixels` = all zero
  - capture register = 0
- Latency: `start` is sampled at edge E0. Group g is written at edge E(g+1). `done` rises at edge E(64/LANES), which is E8 for the default `LANES`.
- Back-to-back operation: a `start` held high in DONE restarts the block at the next edge. Throughput is one block per 64/LANES+1 cycles.
- There is no combinational path from inputs to outputs.

## Configuration
- `DEQUANT_SATURATE_EN` defined:
  - p > 32767 gives 32'h7FFF0000.
  - p < −32768 gives 32'h80000000.
- `DEQUANT_SATURATE_EN` undefined: the result wraps, keeping the low 16 bits of p as the integer part.
- Latency is identical in both builds.

## Structure
- Shared package `jpeg_quant_pkg` holds the following. `quantize_array` uses the same package.
  - the standard 64-entry luma table
  - the standard 64-entry chroma table
  - the `PIXEL_COUNT`=64 constant
  - the coefficient width 16
  - the Q16.16 width 32
- Sub-module `dequant_lane` is one multiplier plus the saturate/wrap logic, instantiated LANES times. Table lookup is indexed by i from the package constants.

## Test plan
- Reset: `rst_n`=0 for 2 edges → `done`=0 and `pixels`==0. Release with no `start` → still 0 after 20 cycles.
- Chroma (`USE_LUMA`=0), all q=1 → the following hold, and `done` rises exactly 8 edges after the `start` edge:
  - `pixels[0]`=32'h00110000 (17)
  - `pixels[63]`=32'h00630000 (99)
- Chroma, q[0]=16'hFFFD (−3), all others 0 → `pixels[0]`=32'hFFCD0000 (−51) and every other output 0. Luma build, same stimulus → 32'hFFD00000 (−48).
- Chroma, q[63]=16'h7FFF → with `DEQUANT_SATURATE_EN`, `pixels[63]`=32'h7FFF0000. Without it, 32'h7F9D0000 (32767×99 mod 2^16). Also q[63]=16'h8000 with saturation → 32'h80000000.
- Handshake:
  - `start` pulsed again at E3 of a RUN → ignored. Result equals the first block and `done` rises at E8.
  - `start` held continuously → `done` falls at the restart edge and rises 8 edges later with the new block.
- Mid-operation reset: `rst_n`=0 at E4 of RUN → next edge shows state IDLE, `pixels`=0 and `done`=0. A following block completes with correct values.
